// File: rtl/weight_seq_pkg.sv
// Shared types and helpers for the weight-loop sequencer.
package weight_seq_pkg;

  localparam int unsigned CntWidth = 32;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StLoad,
    StCompute,
    StDone
  } seq_state_e;

  function automatic int unsigned tile_count(input int unsigned o_t, input int unsigned i_t,
                                             input int unsigned w_w, input int unsigned w_h);
    return o_t * i_t * w_w * w_h;
  endfunction

  // Register width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/loop_wrap_counter.sv
// Single loop index: counts 0..max on inc, flags the carry on the wrapping increment.
module loop_wrap_counter #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic [Width-1:0] max,
  output logic [Width-1:0] count,
  output logic             wrap
);

  logic [Width-1:0] count_q;

  assign wrap  = inc && (count_q == max);
  assign count = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= wrap ? '0 : count_q + Width'(1);
    end
  end

endmodule

// File: rtl/weight_loop_sequencer.sv
// Walks the I_CH tile / W_W / W_H / O_CH tile weight loops, one load+compute handshake per tile.
// Define WEIGHT_SEQ_STALL_CNT_EN to add the saturating load_stall_cnt_out port.
module weight_loop_sequencer
  import weight_seq_pkg::*;
#(
  parameter int unsigned MAC_ROW           = 16,
  parameter int unsigned MAC_COL           = 16,
  parameter int unsigned OFMAP_CHANNEL_NUM = 64,
  parameter int unsigned IFMAP_CHANNEL_NUM = 32,
  parameter int unsigned WEIGHT_WIDTH      = 3,
  parameter int unsigned WEIGHT_HEIGHT     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_in,
  input  logic                abort_in,
  input  logic                load_done_in,
  input  logic                compute_done_in,
  output logic                w_start_out,
  output logic [CntWidth-1:0] O_CH_MAC_COL_count,
  output logic [CntWidth-1:0] I_CH_MAC_ROW_count,
  output logic [CntWidth-1:0] W_W_count,
  output logic [CntWidth-1:0] W_H_count,
  output logic                busy_out,
  output logic                done_out
`ifdef WEIGHT_SEQ_STALL_CNT_EN
  ,
  output logic [CntWidth-1:0] load_stall_cnt_out
`endif
);

  localparam int unsigned OT    = (MAC_COL == 0) ? 0 : OFMAP_CHANNEL_NUM / MAC_COL;
  localparam int unsigned IT    = (MAC_ROW == 0) ? 0 : IFMAP_CHANNEL_NUM / MAC_ROW;
  localparam int unsigned Tiles = tile_count(OT, IT, WEIGHT_WIDTH, WEIGHT_HEIGHT);
  localparam int unsigned OW    = cnt_bits(OT);
  localparam int unsigned IW    = cnt_bits(IT);
  localparam int unsigned WW    = cnt_bits(WEIGHT_WIDTH);
  localparam int unsigned HW    = cnt_bits(WEIGHT_HEIGHT);

  // Any zero parameter collapses Tiles to 0.
  if ((Tiles == 0) || (OT * MAC_COL != OFMAP_CHANNEL_NUM) ||
      (IT * MAC_ROW != IFMAP_CHANNEL_NUM)) begin : g_param_check
    $error("weight_loop_sequencer: zero parameter or inexact channel tiling");
  end

  seq_state_e state_q;
  logic       w_start_q, busy_q, done_q;
  logic       adv, i_wrap, w_wrap, h_wrap, last_tile;
  logic [IW-1:0] i_cnt;
  logic [WW-1:0] w_cnt;
  logic [HW-1:0] h_cnt;
  logic [OW-1:0] o_cnt;

  // The last tile's increment wraps every counter, which doubles as the DONE clear.
  assign adv = (state_q == StCompute) && compute_done_in;

  loop_wrap_counter #(.Width(IW)) u_i_cnt (
    .clk(clk), .rst(rst), .inc(adv), .clr(abort_in), .max(IW'(IT - 1)),
    .count(i_cnt), .wrap(i_wrap)
  );
  loop_wrap_counter #(.Width(WW)) u_w_cnt (
    .clk(clk), .rst(rst), .inc(i_wrap), .clr(abort_in), .max(WW'(WEIGHT_WIDTH - 1)),
    .count(w_cnt), .wrap(w_wrap)
  );
  loop_wrap_counter #(.Width(HW)) u_h_cnt (
    .clk(clk), .rst(rst), .inc(w_wrap), .clr(abort_in), .max(HW'(WEIGHT_HEIGHT - 1)),
    .count(h_cnt), .wrap(h_wrap)
  );
  loop_wrap_counter #(.Width(OW)) u_o_cnt (
    .clk(clk), .rst(rst), .inc(h_wrap), .clr(abort_in), .max(OW'(OT - 1)),
    .count(o_cnt), .wrap(last_tile)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      w_start_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      w_start_q <= 1'b0;
      done_q    <= 1'b0;
      if (abort_in) begin
        state_q <= StIdle;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_in) begin
              state_q   <= StIssue;
              w_start_q <= 1'b1;
              busy_q    <= 1'b1;
            end
          end
          StIssue: state_q <= StLoad;
          StLoad: begin
            if (load_done_in) state_q <= StCompute;
          end
          StCompute: begin
            if (compute_done_in) begin
              if (last_tile) begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end else begin
                state_q   <= StIssue;
                w_start_q <= 1'b1;
              end
            end
          end
          StDone: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign w_start_out        = w_start_q;
  assign busy_out           = busy_q;
  assign done_out           = done_q;
  assign O_CH_MAC_COL_count = CntWidth'(o_cnt);
  assign I_CH_MAC_ROW_count = CntWidth'(i_cnt);
  assign W_W_count          = CntWidth'(w_cnt);
  assign W_H_count          = CntWidth'(h_cnt);

`ifdef WEIGHT_SEQ_STALL_CNT_EN
  logic [CntWidth-1:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if ((state_q == StIdle) && start_in && !abort_in) begin
      stall_q <= '0;
    end else if ((state_q == StLoad) && (stall_q != '1)) begin
      stall_q <= stall_q + CntWidth'(1);
    end
  end

  assign load_stall_cnt_out = stall_q;
`endif

endmodule
